cacc_dlv_credit_buf: RTL and testbench
======================================

Name: cacc_dlv_credit_buf

Overview:
- Parametrised delivery buffer at the accumulator-to-SDP boundary of the convolution accumulator.
- Stores finished accumulated atoms (ATOMK channels each) from the accumulator datapath.
- Slices each atom into SDP-width beats under valid/ready, returns batched entry credits to the sequence controller, and raises ping-pong layer-done interrupts.
- Generalises the fixed 32-channel / 512-bit delivery path to configurable channel count, element width, SDP width, depth and credit batching.

Parameters:
- ATOMK, 32, channels per accumulated atom.
- OUT_W, 32, bits per channel element.
- SDP_CH, 16, channels per SDP beat; ATOMK must be a multiple of SDP_CH.
- DEPTH, 8, atom entries buffered; must be ≥2.
- CREDIT_BATCH, 4, drained atoms per credit pulse; must be ≤ 2^CREDIT_W-1.
- CREDIT_W, 3, width of the credit size field.

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  asynchronous active-low reset
- dlv_valid  in  1  atom write strobe; no backpressure, credit-protected
- dlv_data  in  ATOMK*OUT_W  atom payload; channel 0 in the LSBs
- dlv_stripe_end  in  1  atom is the last of a stripe
- dlv_layer_end  in  1  atom is the last of a layer
- cacc2sdp_valid  out  1  beat valid
- cacc2sdp_ready  in  1  beat accept
- cacc2sdp_pd  out  SDP_CH*OUT_W+2  [SDP_CH*OUT_W-1:0] data; [+0] batch_end; [+1] layer_end
- accu2sc_credit_vld  out  1  credit pulse
- accu2sc_credit_size  out  CREDIT_W  number of atoms freed
- cacc2glb_done_intr_pd  out  2  one-cycle done pulse; bit = layer ping-pong pointer
- dlv_overflow  out  1  sticky error flag
- buf_level  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset values: every output is 0; the FIFO is empty; beat_cnt, credit_cnt and layer_ptr are 0.
- Write path: when dlv_valid=1, the atom plus both end flags enter the FIFO at the clock edge. The earliest cacc2sdp_valid is the next cycle (1-cycle latency).
- Read path: BEATS = ATOMK/SDP_CH.
  - beat_cnt selects slice beat_cnt*SDP_CH*OUT_W of the head atom.
  - Advance only on valid&&ready.
  - On handshake with beat_cnt==BEATS-1: pop the head, set beat_cnt=0.
- Output rules:
  - cacc2sdp_valid = !empty.
  - pd and valid are held stable while valid&&!ready.
  - batch_end = stripe_end && last beat; layer_end = layer_end && last beat; both are 0 on other beats.
- Full handling: full means buf_level==DEPTH.
  - A write on a full FIFO with a simultaneous final-beat pop is accepted.
  - A write on a full FIFO with no pop is dropped, sets dlv_overflow (cleared only by reset), and leaves the FIFO unchanged.
- buf_level follows +1 per write, −1 per pop, unchanged when both occur.
- Credits:
  - On each atom pop, credit_cnt increments.
  - When the incremented value reaches CREDIT_BATCH, or the popped atom has layer_end, the next cycle drives credit_vld=1 with size = that value, and credit_cnt becomes 0.
  - No zero-size credit is ever issued.
- Done interrupt:
  - Popping a layer_end atom drives cacc2glb_done_intr_pd[layer_ptr]=1 for one cycle, in the same cycle as its flush credit.
  - layer_ptr then toggles.
- Reset mid-operation: asynchronous assertion clears the FIFO, counters and pointer immediately. Buffered atoms are discarded; no credit is issued for them.
- State: beat_cnt wraps at BEATS. The FIFO pointers wrap modulo DEPTH, so a non-power-of-two DEPTH needs explicit wrap.

Decomposition:
- Shared package cacc_pkg holds:
  - the constants ATOMK, OUT_W, SDP_CH and BEATS;
  - the pd bit positions BATCH_END_BIT and LAYER_END_BIT;
  - the credit width.
- Sub-module cacc_dlv_fifo: synchronous FIFO with DEPTH×(ATOMK*OUT_W+2) entries, push/pop/full/empty/level, registered head. The top level holds the beat slicer, credit and interrupt logic.

Test Plan:
- Single atom: dlv_data channel k = k, stripe_end=1, ready=1 throughout.
  - cacc2sdp_valid high on cycles 1–2.
  - Beat 0 carries channels 0–15, beat 1 carries channels 16–31.
  - batch_end=1 on beat 1 only.
  - No credit (count 1 < 4).
- Eight back-to-back atoms with ready=1:
  - credit_vld pulses twice, each with size=4, one cycle after the 4th and 8th pops.
  - buf_level returns to 0.
- Three atoms, the third with layer_end:
  - credit size=3 and done_intr_pd=2'b01 in the same cycle.
  - A repeated layer yields 2'b10.
- Backpressure: ready=0 for 10 cycles during beat 1.
  - pd stays stable.
  - Ten writes against DEPTH=8: the 9th and 10th are dropped, dlv_overflow=1, buf_level=8.
- Full with a simultaneous write and final-beat pop: the write is accepted, buf_level stays 8, dlv_overflow stays 0.
- Reset asserted with buf_level=5 and credit_cnt=2:
  - All outputs are 0 immediately.
  - No credit pulse follows deassertion.

Source files
------------

// File: rtl/cacc_pkg.sv
// cacc_pkg: shared constants for the accumulator-to-SDP delivery path
package cacc_pkg;
  localparam int ATOMK = 32;
  localparam int OUT_W = 32;
  localparam int SDP_CH = 16;
  localparam int BEATS = ATOMK / SDP_CH;
  localparam int DEPTH = 8;
  localparam int CREDIT_BATCH = 4;
  localparam int CREDIT_W = 3;
  localparam int BATCH_END_BIT = SDP_CH * OUT_W;
  localparam int LAYER_END_BIT = BATCH_END_BIT + 1;
  function automatic int clog2_min1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cacc_dlv_credit_buf_if.sv
// cacc_dlv_credit_buf_if: atom write bus and SDP beat stream of the delivery buffer
interface cacc_dlv_credit_buf_if #(
  parameter int ATOMK = cacc_pkg::ATOMK,
  parameter int OUT_W = cacc_pkg::OUT_W,
  parameter int SDP_CH = cacc_pkg::SDP_CH
);
  logic dlv_valid;
  logic [ATOMK*OUT_W-1:0] dlv_data;
  logic dlv_stripe_end;
  logic dlv_layer_end;
  logic cacc2sdp_valid;
  logic cacc2sdp_ready;
  logic [SDP_CH*OUT_W+1:0] cacc2sdp_pd;
  modport master (
    output dlv_valid, dlv_data, dlv_stripe_end, dlv_layer_end, cacc2sdp_ready,
    input cacc2sdp_valid, cacc2sdp_pd
  );
  modport slave (
    input dlv_valid, dlv_data, dlv_stripe_end, dlv_layer_end, cacc2sdp_ready,
    output cacc2sdp_valid, cacc2sdp_pd
  );
endinterface

// File: rtl/cacc_dlv_fifo.sv
// cacc_dlv_fifo: flop-array atom FIFO with head read straight from the storage registers
module cacc_dlv_fifo #(
  parameter int W = cacc_pkg::ATOMK * cacc_pkg::OUT_W + 2,
  parameter int DEPTH = cacc_pkg::DEPTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign head = mem[rd_ptr];
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  // storage write; payload needs no reset because head is only observed when non-empty
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  // pointers wrap explicitly so any DEPTH works, level tracks push minus pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr == AW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == AW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
endmodule

// File: rtl/cacc_dlv_credit_buf.sv
// cacc_dlv_credit_buf: buffers accumulated atoms, slices them into SDP beats, returns credits and done interrupts
module cacc_dlv_credit_buf #(
  parameter int ATOMK = cacc_pkg::ATOMK,
  parameter int OUT_W = cacc_pkg::OUT_W,
  parameter int SDP_CH = cacc_pkg::SDP_CH,
  parameter int DEPTH = cacc_pkg::DEPTH,
  parameter int CREDIT_BATCH = cacc_pkg::CREDIT_BATCH,
  parameter int CREDIT_W = cacc_pkg::CREDIT_W
) (
  input  logic nvdla_core_clk,
  input  logic nvdla_core_rstn,
  cacc_dlv_credit_buf_if.slave bus,
  output logic accu2sc_credit_vld,
  output logic [CREDIT_W-1:0] accu2sc_credit_size,
  output logic [1:0] cacc2glb_done_intr_pd,
  output logic dlv_overflow,
  output logic [$clog2(DEPTH+1)-1:0] buf_level
);
  localparam int DW = ATOMK * OUT_W;
  localparam int PD_DW = SDP_CH * OUT_W;
  localparam int BEATS = ATOMK / SDP_CH;
  localparam int BCW = cacc_pkg::clog2_min1(BEATS);
  logic [DW+1:0] head;
  logic empty, full, fire, last, pop, push, flush, layer_pop, layer_ptr;
  logic [BCW-1:0] beat_cnt;
  logic [CREDIT_W-1:0] credit_cnt, credit_inc;
  assign fire = !empty && bus.cacc2sdp_ready;
  assign last = beat_cnt == BCW'(BEATS - 1);
  assign pop = fire && last;
  assign push = bus.dlv_valid && (!full || pop);
  assign layer_pop = pop && head[DW+1];
  assign credit_inc = credit_cnt + 1'b1;
  assign flush = credit_inc == CREDIT_W'(CREDIT_BATCH) || head[DW+1];
  assign bus.cacc2sdp_valid = !empty;
  assign bus.cacc2sdp_pd = empty ? '0 : {head[DW+1] && last, head[DW] && last, head[beat_cnt*PD_DW +: PD_DW]};
  cacc_dlv_fifo #(.W(DW + 2), .DEPTH(DEPTH)) u_fifo (
    .clk(nvdla_core_clk),
    .rst_n(nvdla_core_rstn),
    .push(push),
    .pop(pop),
    .din({bus.dlv_layer_end, bus.dlv_stripe_end, bus.dlv_data}),
    .head(head),
    .full(full),
    .empty(empty),
    .level(buf_level)
  );
  // beat slicer: step through the head atom one accepted beat at a time
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) beat_cnt <= '0;
    else if (fire) beat_cnt <= last ? '0 : beat_cnt + 1'b1;
  // credit batching plus layer-done interrupt, both flushed one cycle after the pop
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) begin
      credit_cnt <= '0;
      accu2sc_credit_vld <= 1'b0;
      accu2sc_credit_size <= '0;
      cacc2glb_done_intr_pd <= 2'b00;
      layer_ptr <= 1'b0;
    end else begin
      if (pop) credit_cnt <= flush ? '0 : credit_inc;
      accu2sc_credit_vld <= pop && flush;
      accu2sc_credit_size <= pop && flush ? credit_inc : '0;
      cacc2glb_done_intr_pd <= layer_pop ? (layer_ptr ? 2'b10 : 2'b01) : 2'b00;
      layer_ptr <= layer_ptr ^ layer_pop;
    end
  // a write arriving while full and without a freeing pop is lost; remember it until reset
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) dlv_overflow <= 1'b0;
    else if (bus.dlv_valid && full && !pop) dlv_overflow <= 1'b1;
endmodule

// File: tb/tb_cacc_dlv_credit_buf.sv
// tb_cacc_dlv_credit_buf: scoreboard bench for the delivery credit buffer
module tb_cacc_dlv_credit_buf;
  localparam int DW = 1024;
  localparam int PW = 514;
  typedef struct {
    logic [DW-1:0] d;
    logic s;
    logic l;
  } atom_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic credit_vld;
  logic [2:0] credit_size;
  logic [1:0] intr;
  logic ovf;
  logic [3:0] level;
  int checks = 0;
  int errors = 0;
  int cpulses = 0;
  logic [2:0] last_cs = '0;
  logic [1:0] last_intr = '0;
  atom_t q[$];
  int mbeat, mcc;
  logic mptr, movf, ecv, nv;
  logic [2:0] ecs, ns;
  logic [1:0] eintr, ni;
  atom_t e;
  logic [PW-1:0] epd;
  always #5 clk = ~clk;
  cacc_dlv_credit_buf_if bus ();
  cacc_dlv_credit_buf dut (
    .nvdla_core_clk(clk),
    .nvdla_core_rstn(rstn),
    .bus(bus),
    .accu2sc_credit_vld(credit_vld),
    .accu2sc_credit_size(credit_size),
    .cacc2glb_done_intr_pd(intr),
    .dlv_overflow(ovf),
    .buf_level(level)
  );
  function automatic logic [DW-1:0] mk(input int base);
    logic [DW-1:0] a;
    for (int k = 0; k < 32; k++) a[k*32 +: 32] = 32'(base + k);
    return a;
  endfunction
  // reference model and scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (!rstn) begin
      q.delete();
      mbeat = 0; mcc = 0; mptr = 0; movf = 0; ecv = 0; ecs = 0; eintr = 0;
    end else begin
      checks++;
      if (bus.cacc2sdp_valid !== (q.size() != 0)) begin errors++; $display("FAIL mon_valid got %b want %b t=%0t", bus.cacc2sdp_valid, q.size() != 0, $time); end
      checks++;
      if (level !== 4'(q.size())) begin errors++; $display("FAIL mon_level got %0d want %0d t=%0t", level, q.size(), $time); end
      checks++;
      if (ovf !== movf) begin errors++; $display("FAIL mon_overflow got %b want %b t=%0t", ovf, movf, $time); end
      checks++;
      if (credit_vld !== ecv) begin errors++; $display("FAIL mon_credit_vld got %b want %b t=%0t", credit_vld, ecv, $time); end
      if (ecv) begin
        checks++;
        if (credit_size !== ecs) begin errors++; $display("FAIL mon_credit_size got %0d want %0d t=%0t", credit_size, ecs, $time); end
      end
      checks++;
      if (intr !== eintr) begin errors++; $display("FAIL mon_intr got %b want %b t=%0t", intr, eintr, $time); end
      if (q.size() != 0) begin
        e = q[0];
        epd = {e.l && mbeat == 1, e.s && mbeat == 1, e.d[mbeat*512 +: 512]};
        checks++;
        if (bus.cacc2sdp_pd !== epd) begin errors++; $display("FAIL mon_pd got %h want %h t=%0t", bus.cacc2sdp_pd, epd, $time); end
      end
      if (credit_vld) begin cpulses++; last_cs = credit_size; end
      if (intr != 0) last_intr = intr;
      nv = 0; ns = 0; ni = 0;
      if (q.size() != 0 && bus.cacc2sdp_ready) begin
        if (mbeat == 1) begin
          e = q.pop_front();
          mbeat = 0;
          mcc++;
          if (mcc == 4 || e.l) begin nv = 1; ns = 3'(mcc); mcc = 0; end
          if (e.l) begin ni = mptr ? 2'b10 : 2'b01; mptr = !mptr; end
        end else mbeat++;
      end
      if (bus.dlv_valid) begin
        if (q.size() < 8) q.push_back('{bus.dlv_data, bus.dlv_stripe_end, bus.dlv_layer_end});
        else movf = 1;
      end
      ecv = nv; ecs = ns; eintr = ni;
    end
  end
  task automatic write_atoms(input int n, input int base, input logic stripe, input logic layer);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.dlv_valid = 1'b1;
      bus.dlv_data = mk(base + i * 100);
      bus.dlv_stripe_end = stripe;
      bus.dlv_layer_end = layer && (i == n - 1);
    end
    @(posedge clk); #1;
    bus.dlv_valid = 1'b0;
    bus.dlv_stripe_end = 1'b0;
    bus.dlv_layer_end = 1'b0;
  endtask
  task automatic do_reset();
    @(posedge clk); #1;
    bus.dlv_valid = 1'b0;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (bus.cacc2sdp_valid !== 1'b0 || credit_vld !== 1'b0 || intr !== 2'b00 || ovf !== 1'b0 || level !== 4'd0 || bus.cacc2sdp_pd !== '0) begin
      errors++; $display("FAIL reset_outputs got v=%b c=%b i=%b o=%b l=%0d want all 0", bus.cacc2sdp_valid, credit_vld, intr, ovf, level);
    end
    #1 rstn = 1'b1;
  endtask
  task automatic test_single();
    int p0;
    do_reset();
    bus.cacc2sdp_ready = 1'b1;
    p0 = cpulses;
    write_atoms(1, 0, 1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if (bus.cacc2sdp_valid !== 1'b1 || bus.cacc2sdp_pd[31:0] !== 32'd0 || bus.cacc2sdp_pd[511:480] !== 32'd15 || bus.cacc2sdp_pd[512] !== 1'b0) begin
      errors++; $display("FAIL single_beat0 got v=%b ch0=%0d ch15=%0d be=%b want v=1 ch0=0 ch15=15 be=0", bus.cacc2sdp_valid, bus.cacc2sdp_pd[31:0], bus.cacc2sdp_pd[511:480], bus.cacc2sdp_pd[512]);
    end
    @(negedge clk);
    checks++;
    if (bus.cacc2sdp_valid !== 1'b1 || bus.cacc2sdp_pd[31:0] !== 32'd16 || bus.cacc2sdp_pd[511:480] !== 32'd31 || bus.cacc2sdp_pd[513:512] !== 2'b01) begin
      errors++; $display("FAIL single_beat1 got v=%b ch16=%0d ch31=%0d ends=%b want v=1 ch16=16 ch31=31 ends=01", bus.cacc2sdp_valid, bus.cacc2sdp_pd[31:0], bus.cacc2sdp_pd[511:480], bus.cacc2sdp_pd[513:512]);
    end
    @(negedge clk);
    checks++;
    if (bus.cacc2sdp_valid !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", bus.cacc2sdp_valid); end
    repeat (4) @(negedge clk);
    checks++;
    if (cpulses - p0 != 0) begin errors++; $display("FAIL single_no_credit got %0d want 0", cpulses - p0); end
  endtask
  task automatic test_back_to_back();
    int p0;
    do_reset();
    bus.cacc2sdp_ready = 1'b1;
    p0 = cpulses;
    write_atoms(8, 1000, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    checks++;
    if (cpulses - p0 != 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", cpulses - p0); end
    checks++;
    if (last_cs !== 3'd4) begin errors++; $display("FAIL b2b_size got %0d want 4", last_cs); end
    checks++;
    if (level !== 4'd0) begin errors++; $display("FAIL b2b_level got %0d want 0", level); end
  endtask
  task automatic test_layer();
    int p0;
    do_reset();
    bus.cacc2sdp_ready = 1'b1;
    p0 = cpulses;
    write_atoms(3, 2000, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    checks++;
    if (cpulses - p0 != 1 || last_cs !== 3'd3) begin errors++; $display("FAIL layer_credit got n=%0d size=%0d want n=1 size=3", cpulses - p0, last_cs); end
    checks++;
    if (last_intr !== 2'b01) begin errors++; $display("FAIL layer_intr0 got %b want 01", last_intr); end
    write_atoms(3, 2500, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    checks++;
    if (last_intr !== 2'b10) begin errors++; $display("FAIL layer_intr1 got %b want 10", last_intr); end
  endtask
  task automatic test_backpressure();
    logic [PW-1:0] hold;
    do_reset();
    bus.cacc2sdp_ready = 1'b0;
    write_atoms(1, 3000, 1'b1, 1'b0);
    bus.cacc2sdp_ready = 1'b1;
    @(posedge clk); #1;
    bus.cacc2sdp_ready = 1'b0;
    @(negedge clk);
    hold = bus.cacc2sdp_pd;
    checks++;
    if (hold[512] !== 1'b1) begin errors++; $display("FAIL bp_beat1 got be=%b want 1", hold[512]); end
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      bus.dlv_valid = 1'b1;
      bus.dlv_data = mk(3100 + i * 100);
      @(negedge clk);
      checks++;
      if (bus.cacc2sdp_pd !== hold || bus.cacc2sdp_valid !== 1'b1) begin errors++; $display("FAIL bp_stable got %h want %h", bus.cacc2sdp_pd, hold); end
    end
    @(posedge clk); #1;
    bus.dlv_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (level !== 4'd8 || ovf !== 1'b1) begin errors++; $display("FAIL bp_full got lvl=%0d ovf=%b want lvl=8 ovf=1", level, ovf); end
    bus.cacc2sdp_ready = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (level !== 4'd0 || ovf !== 1'b1) begin errors++; $display("FAIL bp_drain got lvl=%0d ovf=%b want lvl=0 ovf=1", level, ovf); end
  endtask
  task automatic test_full_pop();
    do_reset();
    bus.cacc2sdp_ready = 1'b0;
    write_atoms(8, 4000, 1'b0, 1'b0);
    bus.cacc2sdp_ready = 1'b1;
    @(posedge clk); #1;
    bus.dlv_valid = 1'b1;
    bus.dlv_data = mk(4900);
    @(posedge clk); #1;
    bus.dlv_valid = 1'b0;
    bus.cacc2sdp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (level !== 4'd8 || ovf !== 1'b0) begin errors++; $display("FAIL full_pop got lvl=%0d ovf=%b want lvl=8 ovf=0", level, ovf); end
    bus.cacc2sdp_ready = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (level !== 4'd0) begin errors++; $display("FAIL full_pop_drain got %0d want 0", level); end
  endtask
  task automatic test_reset_mid();
    int p0;
    do_reset();
    bus.cacc2sdp_ready = 1'b0;
    write_atoms(7, 6000, 1'b0, 1'b0);
    bus.cacc2sdp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 bus.cacc2sdp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (level !== 4'd5) begin errors++; $display("FAIL mid_level got %0d want 5", level); end
    p0 = cpulses;
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    checks++;
    if (bus.cacc2sdp_valid !== 1'b0 || level !== 4'd0 || bus.cacc2sdp_pd !== '0 || credit_vld !== 1'b0 || intr !== 2'b00 || ovf !== 1'b0) begin
      errors++; $display("FAIL mid_async got v=%b l=%0d c=%b i=%b o=%b want all 0", bus.cacc2sdp_valid, level, credit_vld, intr, ovf);
    end
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    bus.cacc2sdp_ready = 1'b1;
    repeat (8) @(negedge clk);
    checks++;
    if (cpulses != p0 || bus.cacc2sdp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_credit got n=%0d v=%b want n=0 v=0", cpulses - p0, bus.cacc2sdp_valid); end
  endtask
  initial begin
    bus.dlv_valid = 1'b0;
    bus.dlv_data = '0;
    bus.dlv_stripe_end = 1'b0;
    bus.dlv_layer_end = 1'b0;
    bus.cacc2sdp_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_layer();
    test_backpressure();
    test_full_pop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
